// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants, FSM state type and event record for the PS/2 key decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  // Scan-code set 2 prefix bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Fake-shift codes the keyboard wraps around some extended keys
  localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

  // Frogger control keys (arrows are E0-prefixed, space is not)
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  // Bytes that follow E1 in the Pause sequence
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXTBRK,
    SKIP
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  // Keyboard status/reply bytes that are not key codes
  function automatic logic is_noise(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key-event stream from the decoder to the game controller.
// Latency: n/a (wiring only).
// Backpressure: consumer holds ev_ready low to keep the head event.
interface ps2_key_decoder_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;

  modport master (output ev_valid, output ev_code, output ev_ext, output ev_break,
                  input  ev_ready);
  modport slave  (input  ev_valid, input  ev_code, input  ev_ext, input  ev_break,
                  output ev_ready);
endinterface

// File: rtl/ps2_key_decoder_fifo.sv
// Synchronous event FIFO holding decoded key events.
// Latency: pushed entry visible at head one cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens on the same edge.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  ev_t  push_dat_i,
  input  logic pop_i,
  output ev_t  head_dat_o,
  output logic full_o,
  output logic empty_o,
  output logic drop_o
);

  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

  ev_t              mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             pop_ok, push_ok;

  assign full_o     = (cnt_q == DEPTH_C);
  assign empty_o    = (cnt_q == '0);
  assign pop_ok     = pop_i & ~empty_o;
  // A pop on the same edge frees the slot the push needs
  assign push_ok    = push_i & (~full_o | pop_ok);
  assign drop_o     = push_i & ~push_ok;
  assign head_dat_o = mem_q[rd_ptr_q];

  // Storage: written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes set-2 scan bytes (E0/F0/E1 prefixes) into queued make/break events and held key flags.
// Latency: event and key flags update 1 cycle after rx_done_tick; rx_ack pulses the same cycle.
// Backpressure: events dropped into sticky ev_overflow when the FIFO is full; PS2_REPEAT_FILTER_EN drops typematic repeats.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [7:0]            rx_data,
  output logic                  rx_ack,
  ps2_key_decoder_if.master     ev,
  output logic                  ev_overflow,
  output logic                  key_up,
  output logic                  key_down,
  output logic                  key_left,
  output logic                  key_right,
  output logic                  key_space
);

  state_t     state_q, state_d;
  logic [2:0] skip_cnt_q, skip_cnt_d;
  logic       emit, push, drop, fifo_empty, fifo_full;
  ev_t        emit_ev, head_ev;
  logic       rx_ack_q, overflow_q;
  logic       up_q, down_q, left_q, right_q, space_q;
  logic       fake_shift;

  assign fake_shift = (rx_data == PS2_FAKE_LSHIFT) || (rx_data == PS2_FAKE_RSHIFT);

  // Prefix state register and Pause byte counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  // Prefix decode: next state and the event produced by the current byte
  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    emit         = 1'b0;
    emit_ev      = '0;
    emit_ev.code = rx_data;
    if (rx_done_tick) begin
      case (state_q)
        IDLE: begin
          if (rx_data == PS2_EXT) begin
            state_d = EXT;
          end else if (rx_data == PS2_BRK) begin
            state_d = BRK;
          end else if (rx_data == PS2_PAUSE) begin
            state_d    = SKIP;
            skip_cnt_d = PAUSE_TAIL;
          end else if (!is_noise(rx_data)) begin
            emit = 1'b1;
          end
        end
        EXT: begin
          if (rx_data == PS2_BRK) begin
            state_d = EXTBRK;
          end else begin
            state_d     = IDLE;
            emit        = ~fake_shift;
            emit_ev.ext = 1'b1;
          end
        end
        BRK: begin
          state_d     = IDLE;
          emit        = 1'b1;
          emit_ev.brk = 1'b1;
        end
        EXTBRK: begin
          state_d     = IDLE;
          emit        = ~fake_shift;
          emit_ev.ext = 1'b1;
          emit_ev.brk = 1'b1;
        end
        SKIP: begin
          skip_cnt_d = skip_cnt_q - 3'd1;
          if (skip_cnt_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [7:0] last_code_q;
  logic       last_ext_q, last_vld_q, same_key;

  assign same_key = last_vld_q && (last_code_q == emit_ev.code) && (last_ext_q == emit_ev.ext);
  assign push     = emit & ~(same_key & ~emit_ev.brk);

  // Remember the last make; its break re-arms the filter for that key
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_code_q <= '0;
      last_ext_q  <= 1'b0;
      last_vld_q  <= 1'b0;
    end else if (emit) begin
      if (!emit_ev.brk) begin
        last_code_q <= emit_ev.code;
        last_ext_q  <= emit_ev.ext;
        last_vld_q  <= 1'b1;
      end else if (same_key) begin
        last_vld_q  <= 1'b0;
      end
    end
  end
`else
  assign push = emit;
`endif

  ps2_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (emit_ev),
    .pop_i      (ev.ev_ready),
    .head_dat_o (head_ev),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .drop_o     (drop)
  );

  // Receiver acknowledge and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ack_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rx_ack_q <= rx_done_tick;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Held-key levels follow every emitted event regardless of FIFO space
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {up_q, down_q, left_q, right_q, space_q} <= '0;
    end else if (emit) begin
      if (emit_ev.ext) begin
        case (emit_ev.code)
          KEY_UP:    up_q    <= ~emit_ev.brk;
          KEY_DOWN:  down_q  <= ~emit_ev.brk;
          KEY_LEFT:  left_q  <= ~emit_ev.brk;
          KEY_RIGHT: right_q <= ~emit_ev.brk;
          default: ;
        endcase
      end else if (emit_ev.code == KEY_SPACE) begin
        space_q <= ~emit_ev.brk;
      end
    end
  end

  assign rx_ack      = rx_ack_q;
  assign ev_overflow = overflow_q;
  assign ev.ev_valid = ~fifo_empty;
  assign ev.ev_code  = head_ev.code;
  assign ev.ev_ext   = head_ev.ext;
  assign ev.ev_break = head_ev.brk;
  assign key_up      = up_q;
  assign key_down    = down_q;
  assign key_left    = left_q;
  assign key_right   = right_q;
  assign key_space   = space_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random byte streams vs a queue model.
// Latency: outputs compared every negedge against the model updated at each posedge.
// Backpressure: ev_ready randomised; FIFO overflow and typematic filter exercised.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ack, ev_overflow;
  logic       key_up, key_down, key_left, key_right, key_space;

  int checks = 0;
  int errors = 0;

  ps2_key_decoder_if evif ();

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rx_ack       (rx_ack),
    .ev           (evif.master),
    .ev_overflow  (ev_overflow),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_space    (key_space)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [9:0] mq[$];          // {code, ext, brk}
  logic [7:0] pfx[$];         // prefix bytes seen so far for the current key
  int         m_skip;
  logic       m_ack, m_ovf;
  logic [4:0] m_keys;         // up, down, left, right, space
  logic [7:0] l_code;
  logic       l_ext, l_vld;

  function automatic logic noise(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int         c;
    logic       pop, emit, pushv, x, k;
    logic [7:0] b;
    if (reset) begin
      mq.delete(); pfx.delete();
      m_skip = 0; m_ack = 0; m_ovf = 0; m_keys = '0; l_vld = 0; l_code = '0; l_ext = 0;
    end else begin
      c = mq.size();
      pop = evif.ev_ready && c > 0;
      m_ack = rx_done_tick;
      emit = 0; x = 0; k = 0; b = rx_data;
      if (rx_done_tick) begin
        if (m_skip > 0) m_skip--;
        else if (pfx.size() == 0 && b == 8'hE1) m_skip = 7;
        else if (pfx.size() == 0 && b == 8'hE0) pfx.push_back(b);
        else if (b == 8'hF0 && (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0)))
          pfx.push_back(b);
        else begin
          x = pfx.size() > 0 && pfx[0] == 8'hE0;
          foreach (pfx[i]) if (pfx[i] == 8'hF0) k = 1;
          pfx.delete();
          if (x && (b == 8'h12 || b == 8'h59)) emit = 0;
          else if (!x && !k && noise(b)) emit = 0;
          else emit = 1;
        end
      end
      if (pop) void'(mq.pop_front());
      if (emit) begin
        if (x) begin
          if (b == 8'h75) m_keys[4] = !k;
          if (b == 8'h72) m_keys[3] = !k;
          if (b == 8'h6B) m_keys[2] = !k;
          if (b == 8'h74) m_keys[1] = !k;
        end else if (b == 8'h29) m_keys[0] = !k;
        pushv = 1;
`ifdef PS2_REPEAT_FILTER_EN
        if (!k) begin
          if (l_vld && l_code == b && l_ext == x) pushv = 0;
          else begin l_vld = 1; l_code = b; l_ext = x; end
        end else if (l_vld && l_code == b && l_ext == x) l_vld = 0;
`endif
        if (pushv) begin
          if (c < DEPTH || pop) mq.push_back({b, x, k});
          else m_ovf = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("rx_ack", {31'd0, rx_ack}, {31'd0, m_ack});
      chk("ev_valid", {31'd0, evif.ev_valid}, {31'd0, mq.size() > 0});
      if (mq.size() > 0)
        chk("head", {22'd0, evif.ev_code, evif.ev_ext, evif.ev_break}, {22'd0, mq[0]});
      chk("overflow", {31'd0, ev_overflow}, {31'd0, m_ovf});
      chk("keys", {27'd0, key_up, key_down, key_left, key_right, key_space}, {27'd0, m_keys});
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done_tick = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  logic [7:0] codes[5];
  logic [7:0] pool[16];
  logic [7:0] pause_seq[8];
  int         n_ev;
  int         r;

  initial begin
    codes     = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
    pool      = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h75, 8'h72, 8'h6B,
                  8'h74, 8'h29, 8'hAA, 8'h00, 8'h1C, 8'hFF, 8'hF0, 8'hE0};
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    evif.ev_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'd0, rx_ack}, 32'd0);
    chk("rst_valid", {31'd0, evif.ev_valid}, 32'd0);
    chk("rst_ovf", {31'd0, ev_overflow}, 32'd0);
    chk("rst_keys", {27'd0, key_up, key_down, key_left, key_right, key_space}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Extended make/break of up arrow
    evif.ev_ready = 1'b1;
    send_byte(8'hE0);
    send_byte(8'h75);
    chk("up_make", {22'd0, evif.ev_code, evif.ev_ext, evif.ev_break}, {22'd0, 8'h75, 2'b10});
    chk("up_level", {31'd0, key_up}, 32'd1);
    chk("up_ack", {31'd0, rx_ack}, 32'd1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("up_break", {22'd0, evif.ev_code, evif.ev_ext, evif.ev_break}, {22'd0, 8'h75, 2'b11});
    chk("up_clear", {31'd0, key_up}, 32'd0);

    // Space make/break and noise bytes
    send_byte(8'h29);
    chk("sp_make", {22'd0, evif.ev_code, evif.ev_ext, evif.ev_break}, {22'd0, 8'h29, 2'b00});
    chk("sp_level", {31'd0, key_space}, 32'd1);
    send_byte(8'hF0); send_byte(8'h29);
    chk("sp_break", {22'd0, evif.ev_code, evif.ev_ext, evif.ev_break}, {22'd0, 8'h29, 2'b01});
    chk("sp_clear", {31'd0, key_space}, 32'd0);
    send_byte(8'hAA);
    chk("noise_aa", {31'd0, evif.ev_valid}, 32'd0);
    send_byte(8'hFA);
    chk("noise_fa", {31'd0, evif.ev_valid}, 32'd0);

    // Pause sequence produces nothing; following make does
    evif.ev_ready = 1'b0;
    foreach (pause_seq[i]) send_byte(pause_seq[i]);
    chk("pause_none", {31'd0, evif.ev_valid}, 32'd0);
    send_byte(8'h1C);
    chk("after_pause", {22'd0, evif.ev_code, evif.ev_ext, evif.ev_break}, {22'd0, 8'h1C, 2'b00});
    chk("pause_keys", {27'd0, key_up, key_down, key_left, key_right, key_space}, 32'd0);
    evif.ev_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Overflow with FIFO depth 4
    do_reset();
    evif.ev_ready = 1'b0;
    foreach (codes[i]) send_byte(codes[i]);
    chk("ovf_set", {31'd0, ev_overflow}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_valid", {31'd0, evif.ev_valid}, 32'd1);
      chk("ovf_order", {24'd0, evif.ev_code}, {24'd0, codes[i]});
      evif.ev_ready = 1'b1;
      @(posedge clk); #1;
      evif.ev_ready = 1'b0;
    end
    chk("ovf_drained", {31'd0, evif.ev_valid}, 32'd0);

    // Push and pop on the same edge while full
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(codes[i]);
    @(posedge clk); #1;
    evif.ev_ready = 1'b1; rx_done_tick = 1'b1; rx_data = 8'h34;
    @(posedge clk); #1;
    evif.ev_ready = 1'b0; rx_done_tick = 1'b0;
    chk("full_pp_ovf", {31'd0, ev_overflow}, 32'd0);
    chk("full_pp_head", {24'd0, evif.ev_code}, 32'h1B);

    // Reset in the middle of an extended sequence
    send_byte(8'hE0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_empty", {31'd0, evif.ev_valid}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    send_byte(8'h75);
    chk("midrst_code", {22'd0, evif.ev_code, evif.ev_ext, evif.ev_break}, {22'd0, 8'h75, 2'b00});
    chk("midrst_up", {31'd0, key_up}, 32'd0);

    // Typematic repeat of left arrow
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hE0); send_byte(8'h6B);
      chk("left_held", {31'd0, key_left}, 32'd1);
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    chk("left_rel", {31'd0, key_left}, 32'd0);
    n_ev = 0;
    evif.ev_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (evif.ev_valid) n_ev++;
      @(posedge clk); #1;
    end
`ifdef PS2_REPEAT_FILTER_EN
    chk("repeat_count", n_ev, 32'd2);
`else
    chk("repeat_count", n_ev, 32'd4);
`endif

    // Random byte stream with random backpressure
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      rx_done_tick = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 23);
      rx_data = (r < 16) ? pool[r] : 8'($urandom_range(0, 255));
      evif.ev_ready = ((cyc / 200) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (cyc == 2000) reset = 1'b1;
      if (cyc == 2002) reset = 1'b0;
    end
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
